// File: rtl/mc_datapath.sv
// Multi-cycle MIPS-style datapath: one shared ALU, a DECODE/EXEC/MEM/WB walk per instruction,
// and a req/ack data-memory port that gives up after MEM_TIMEOUT cycles without an ack.
module mc_datapath #(
  parameter int DATA_W      = 32,
  parameter int REG_N       = 32,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [31:0]       INST,
  input  logic              regDst,
  input  logic              regWrite,
  input  logic              ALUSrc,
  input  logic [3:0]        ALUcontrol,
  input  logic              memWrite,
  input  logic              memRead,
  input  logic              memtoReg,
  input  logic              inst_valid,
  output logic              inst_ready,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic [DATA_W-1:0] dmem_rdata,
  input  logic              dmem_ack,
  output logic [DATA_W-1:0] regW,
  output logic [DATA_W-1:0] addr,
  output logic              is_Zero,
  output logic              done,
  output logic              err
);

  localparam int RA_W  = (REG_N > 1) ? $clog2(REG_N) : 1;
  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [2:0] {S_IDLE, S_DECODE, S_EXEC, S_MEM, S_WB} state_t;

  state_t              r_state;
  logic [25:0]         r_inst;
  logic                r_reg_dst, r_reg_write, r_alu_src;
  logic                r_mem_write, r_mem_read, r_memto_reg;
  logic [3:0]          r_alu_ctl;
  logic [DATA_W-1:0]   r_a, r_b, r_alu_out, r_mdr;
  logic                r_zero;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_dmem_req, r_dmem_we;
  logic [DATA_W-1:0]   r_dmem_addr, r_dmem_wdata;
  logic [DATA_W-1:0]   r_regw, r_addr;
  logic                r_is_zero, r_done, r_err;
  logic [DATA_W-1:0]   r_rf [REG_N];

  logic [RA_W-1:0]     w_rs, w_rt, w_rd, w_dest;
  logic [DATA_W-1:0]   w_imm_ext, w_alu_b, w_alu_res, w_wd;
  logic                w_rf_we;
  logic                w_unused;

  // Opcode bits are decoded upstream; only the register/immediate fields matter here.
  assign w_unused = ^INST[31:26];

  assign w_rs   = r_inst[21 +: RA_W];
  assign w_rt   = r_inst[16 +: RA_W];
  assign w_rd   = r_inst[11 +: RA_W];
  assign w_dest = r_reg_dst ? w_rd : w_rt;

  generate
    if (DATA_W > 16) begin : g_sext
      assign w_imm_ext = {{(DATA_W-16){r_inst[15]}}, r_inst[15:0]};
    end else begin : g_nosext
      assign w_imm_ext = r_inst[15:0];
    end
  endgenerate

  assign w_alu_b = r_alu_src ? w_imm_ext : r_b;

  always_comb begin
    w_alu_res = '0;
    case (r_alu_ctl)
      4'b0000: w_alu_res = r_a & w_alu_b;
      4'b0001: w_alu_res = r_a | w_alu_b;
      4'b0010: w_alu_res = r_a + w_alu_b;
      4'b0110: w_alu_res = r_a - w_alu_b;
      4'b1100: w_alu_res = ~(r_a | w_alu_b);
      4'b0111: w_alu_res = ($signed(r_a) < $signed(w_alu_b)) ? DATA_W'(1) : '0;
      default: w_alu_res = '0;
    endcase
  end

  assign w_wd    = r_memto_reg ? r_mdr : r_alu_out;
  // Register 0 is never written, so it keeps its reset value of zero.
  assign w_rf_we = (r_state == S_WB) && r_reg_write && (w_dest != '0);

  generate
    for (genvar gi = 0; gi < REG_N; gi++) begin : g_rf
      always_ff @(posedge CLK) begin
        if (RST) begin
          r_rf[gi] <= '0;
        end else if (w_rf_we && (w_dest == RA_W'(gi))) begin
          r_rf[gi] <= w_wd;
        end
      end
    end
  endgenerate

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state      <= S_IDLE;
      r_inst       <= '0;
      r_reg_dst    <= 1'b0;
      r_reg_write  <= 1'b0;
      r_alu_src    <= 1'b0;
      r_alu_ctl    <= '0;
      r_mem_write  <= 1'b0;
      r_mem_read   <= 1'b0;
      r_memto_reg  <= 1'b0;
      r_a          <= '0;
      r_b          <= '0;
      r_alu_out    <= '0;
      r_zero       <= 1'b0;
      r_mdr        <= '0;
      r_cnt        <= '0;
      r_dmem_req   <= 1'b0;
      r_dmem_we    <= 1'b0;
      r_dmem_addr  <= '0;
      r_dmem_wdata <= '0;
      r_regw       <= '0;
      r_addr       <= '0;
      r_is_zero    <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (inst_valid) begin
            r_inst      <= INST[25:0];
            r_reg_dst   <= regDst;
            r_reg_write <= regWrite;
            r_alu_src   <= ALUSrc;
            r_alu_ctl   <= ALUcontrol;
            r_mem_write <= memWrite;
            r_mem_read  <= memRead;
            r_memto_reg <= memtoReg;
            r_state     <= S_DECODE;
          end
        end
        S_DECODE: begin
          r_a     <= r_rf[w_rs];
          r_b     <= r_rf[w_rt];
          r_state <= S_EXEC;
        end
        S_EXEC: begin
          r_alu_out <= w_alu_res;
          r_zero    <= (w_alu_res == '0);
          if (r_mem_read && r_mem_write) begin
            r_err   <= 1'b1;
            r_state <= S_IDLE;
          end else if (r_mem_read || r_mem_write) begin
            r_cnt        <= '0;
            r_dmem_req   <= 1'b1;
            r_dmem_we    <= r_mem_write;
            r_dmem_addr  <= w_alu_res;
            r_dmem_wdata <= r_b;
            r_state      <= S_MEM;
          end else begin
            r_state <= S_WB;
          end
        end
        S_MEM: begin
          // An ack in the final allowed cycle still wins over the timeout.
          if (dmem_ack) begin
            r_mdr      <= dmem_rdata;
            r_dmem_req <= 1'b0;
            r_dmem_we  <= 1'b0;
            r_state    <= S_WB;
          end else if (r_cnt == CNT_W'(MEM_TIMEOUT - 1)) begin
            r_dmem_req <= 1'b0;
            r_dmem_we  <= 1'b0;
            r_err      <= 1'b1;
            r_state    <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_WB: begin
          r_regw    <= w_wd;
          r_addr    <= r_alu_out;
          r_is_zero <= r_zero;
          r_done    <= 1'b1;
          r_state   <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign inst_ready = (r_state == S_IDLE);
  assign dmem_req   = r_dmem_req;
  assign dmem_we    = r_dmem_we;
  assign dmem_addr  = r_dmem_addr;
  assign dmem_wdata = r_dmem_wdata;
  assign regW       = r_regw;
  assign addr       = r_addr;
  assign is_Zero    = r_is_zero;
  assign done       = r_done;
  assign err        = r_err;

endmodule

// File: tb/tb_mc_datapath.sv
// Directed bench for mc_datapath: a vector table run back to back, plus a reset-during-MEM sequence.
module tb_mc_datapath;

  logic        CLK = 1'b0;
  logic        RST;
  logic [31:0] INST;
  logic        regDst, regWrite, ALUSrc, memWrite, memRead, memtoReg, inst_valid;
  logic [3:0]  ALUcontrol;
  logic        inst_ready, dmem_req, dmem_we, dmem_ack, is_Zero, done, err;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata, regW, addr;

  int n_cmp = 0;
  int n_bad = 0;

  mc_datapath dut (
    .CLK(CLK), .RST(RST), .INST(INST), .regDst(regDst), .regWrite(regWrite),
    .ALUSrc(ALUSrc), .ALUcontrol(ALUcontrol), .memWrite(memWrite), .memRead(memRead),
    .memtoReg(memtoReg), .inst_valid(inst_valid), .inst_ready(inst_ready),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack), .regW(regW), .addr(addr),
    .is_Zero(is_Zero), .done(done), .err(err)
  );

  always #5 CLK = ~CLK;

  // ctl = {regDst, regWrite, ALUSrc, ALUcontrol[3:0], memWrite, memRead, memtoReg}
  typedef struct {
    logic [31:0] inst;
    logic [9:0]  ctl;
    int          ack_at;   // MEM cycle on which ack is given; 0 = never
    logic [31:0] rdata;
    logic [31:0] e_regw;
    logic [31:0] e_addr;
    logic        e_zero;
    int          e_lat;    // cycles from accept edge to done/err high
    logic        e_err;
    int          e_req;    // cycles dmem_req is high
    logic        e_we;
    logic [31:0] e_wdata;
    logic [31:0] e_daddr;
  } vec_t;

  localparam logic [9:0] C_ADDI = {1'b0, 1'b1, 1'b1, 4'b0010, 3'b000};
  localparam logic [9:0] C_SW   = {1'b0, 1'b0, 1'b1, 4'b0010, 3'b100};
  localparam logic [9:0] C_LW   = {1'b0, 1'b1, 1'b1, 4'b0010, 3'b011};
  localparam logic [9:0] C_BAD  = {1'b0, 1'b1, 1'b1, 4'b0010, 3'b110};

  function automatic logic [9:0] c_r(input logic [3:0] op);
    return {1'b1, 1'b1, 1'b0, op, 3'b000};
  endfunction

  function automatic logic [31:0] ri(input int rs, input int rt, input int rd);
    return {6'd0, 5'(rs), 5'(rt), 5'(rd), 11'd0};
  endfunction

  function automatic logic [31:0] ii(input int rs, input int rt, input logic [15:0] imm);
    return {6'd0, 5'(rs), 5'(rt), imm};
  endfunction

  function automatic vec_t mkv(input logic [31:0] inst, input logic [9:0] ctl, input int ack_at,
                               input logic [31:0] rdata, input logic [31:0] e_regw,
                               input logic [31:0] e_addr, input logic e_zero, input int e_lat,
                               input logic e_err, input int e_req, input logic e_we,
                               input logic [31:0] e_wdata, input logic [31:0] e_daddr);
    vec_t v;
    v.inst = inst; v.ctl = ctl; v.ack_at = ack_at; v.rdata = rdata;
    v.e_regw = e_regw; v.e_addr = e_addr; v.e_zero = e_zero; v.e_lat = e_lat;
    v.e_err = e_err; v.e_req = e_req; v.e_we = e_we; v.e_wdata = e_wdata; v.e_daddr = e_daddr;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s [v%0d]: got %h expected %h", name, idx, got, exp);
    end
  endtask

  // Issues one instruction at the current negedge and follows it to done/err.
  task automatic run(input int idx, input vec_t v);
    int c, mc, rl;
    bit fin, stable;
    logic got_done, got_err, we_s;
    logic [31:0] wd_s, ad_s;
    c = 0; mc = 0; rl = 0; fin = 0; stable = 1;
    got_done = 0; got_err = 0; we_s = 0; wd_s = 0; ad_s = 0;
    chk("ready_at_issue", idx, 32'(inst_ready), 32'd1);
    INST = v.inst;
    {regDst, regWrite, ALUSrc, ALUcontrol, memWrite, memRead, memtoReg} = v.ctl;
    inst_valid = 1'b1;
    while (!fin && c < 40) begin
      @(negedge CLK);
      c++;
      inst_valid = 1'b0;
      dmem_ack   = 1'b0;
      dmem_rdata = $urandom;
      INST       = $urandom;
      {regDst, regWrite, ALUSrc, ALUcontrol, memWrite, memRead, memtoReg} = 10'($urandom);
      if (c == 1) begin
        chk("pulse_low", idx, 32'({done, err}), 32'd0);
      end else if (done || err) begin
        fin = 1; got_done = done; got_err = err;
      end
      if (!fin) begin
        if (!inst_ready) rl++;
        if (dmem_req) begin
          mc++;
          if (mc == 1) begin
            we_s = dmem_we; wd_s = dmem_wdata; ad_s = dmem_addr;
          end else if (dmem_we !== we_s || dmem_wdata !== wd_s || dmem_addr !== ad_s) begin
            stable = 0;
          end
          if (mc == v.ack_at) begin
            dmem_ack   = 1'b1;
            dmem_rdata = v.rdata;
          end
        end
      end
    end
    if (!fin) begin
      n_cmp++; n_bad++;
      $display("FAIL timeout [v%0d]: no done/err within 40 cycles", idx);
    end else begin
      chk("latency",   idx, 32'(c),        32'(v.e_lat));
      chk("done",      idx, 32'(got_done), 32'(!v.e_err));
      chk("err",       idx, 32'(got_err),  32'(v.e_err));
      chk("regW",      idx, regW,          v.e_regw);
      chk("addr",      idx, addr,          v.e_addr);
      chk("is_Zero",   idx, 32'(is_Zero),  32'(v.e_zero));
      chk("ready_low", idx, 32'(rl),       32'(v.e_lat - 1));
      chk("req_cyc",   idx, 32'(mc),       32'(v.e_req));
      chk("req_off",   idx, 32'(dmem_req), 32'd0);
      if (v.e_req > 0) begin
        chk("dmem_we",    idx, 32'(we_s),   32'(v.e_we));
        chk("dmem_wdata", idx, wd_s,        v.e_wdata);
        chk("dmem_addr",  idx, ad_s,        v.e_daddr);
        chk("req_stable", idx, 32'(stable), 32'd1);
      end
    end
    $display("v%0d inst=%h lat=%0d done=%0b err=%0b regW=%h addr=%h z=%0b req_cyc=%0d",
             idx, v.inst, c, got_done, got_err, regW, addr, is_Zero, mc);
  endtask

  vec_t vecs[22];
  vec_t post[2];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = mkv(ii(0,1,16'd5),      C_ADDI,      0, 0, 32'd5,        32'd5,        0, 4, 0, 0, 0, 0, 0);
    vecs[1]  = mkv(ii(0,2,16'd7),      C_ADDI,      0, 0, 32'd7,        32'd7,        0, 4, 0, 0, 0, 0, 0);
    vecs[2]  = mkv(ri(1,2,3),          c_r(4'b0010),0, 0, 32'd12,       32'd12,       0, 4, 0, 0, 0, 0, 0);
    vecs[3]  = mkv(ri(3,3,4),          c_r(4'b0110),0, 0, 32'd0,        32'd0,        1, 4, 0, 0, 0, 0, 0);
    vecs[4]  = mkv(ri(1,2,6),          c_r(4'b0000),0, 0, 32'd5,        32'd5,        0, 4, 0, 0, 0, 0, 0);
    vecs[5]  = mkv(ri(1,2,7),          c_r(4'b1100),0, 0, 32'hFFFFFFF8, 32'hFFFFFFF8, 0, 4, 0, 0, 0, 0, 0);
    vecs[6]  = mkv(ii(0,8,16'hFFFF),   C_ADDI,      0, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 4, 0, 0, 0, 0, 0);
    vecs[7]  = mkv(ri(8,2,9),          c_r(4'b0111),0, 0, 32'd1,        32'd1,        0, 4, 0, 0, 0, 0, 0);
    vecs[8]  = mkv(ri(2,8,9),          c_r(4'b0111),0, 0, 32'd0,        32'd0,        1, 4, 0, 0, 0, 0, 0);
    vecs[9]  = mkv(ri(1,2,10),         c_r(4'b1111),0, 0, 32'd0,        32'd0,        1, 4, 0, 0, 0, 0, 0);
    vecs[10] = mkv(ii(0,2,16'h0010),   C_SW,        3, 0, 32'h10,       32'h10,       0, 7, 0, 3, 1, 32'd7, 32'h10);
    vecs[11] = mkv(ri(2,0,11),         c_r(4'b0001),0, 0, 32'd7,        32'd7,        0, 4, 0, 0, 0, 0, 0);
    vecs[12] = mkv(ii(0,5,16'h0010),   C_LW,        1, 32'hDEADBEEF, 32'hDEADBEEF, 32'h10, 0, 5, 0, 1, 0, 32'd0, 32'h10);
    vecs[13] = mkv(ri(5,0,12),         c_r(4'b0001),0, 0, 32'hDEADBEEF, 32'hDEADBEEF, 0, 4, 0, 0, 0, 0, 0);
    vecs[14] = mkv(ii(0,5,16'h0020),   C_LW,        0, 0, 32'hDEADBEEF, 32'hDEADBEEF, 0, 18, 1, 15, 0, 32'hDEADBEEF, 32'h20);
    vecs[15] = mkv(ri(5,0,12),         c_r(4'b0001),0, 0, 32'hDEADBEEF, 32'hDEADBEEF, 0, 4, 0, 0, 0, 0, 0);
    vecs[16] = mkv(ii(0,5,16'h0020),   C_LW,       15, 32'h12345678, 32'h12345678, 32'h20, 0, 19, 0, 15, 0, 32'hDEADBEEF, 32'h20);
    vecs[17] = mkv(ri(5,0,13),         c_r(4'b0001),0, 0, 32'h12345678, 32'h12345678, 0, 4, 0, 0, 0, 0, 0);
    vecs[18] = mkv(ri(1,2,0),          c_r(4'b0010),0, 0, 32'd12,       32'd12,       0, 4, 0, 0, 0, 0, 0);
    vecs[19] = mkv(ri(0,0,13),         c_r(4'b0001),0, 0, 32'd0,        32'd0,        1, 4, 0, 0, 0, 0, 0);
    vecs[20] = mkv(ii(0,5,16'h0030),   C_BAD,       0, 0, 32'd0,        32'd0,        1, 3, 1, 0, 0, 0, 0);
    vecs[21] = mkv(ri(1,2,14),         c_r(4'b0110),0, 0, 32'hFFFFFFFE, 32'hFFFFFFFE, 0, 4, 0, 0, 0, 0, 0);
    post[0]  = mkv(ri(1,2,15),         c_r(4'b0001),0, 0, 32'd0,        32'd0,        1, 4, 0, 0, 0, 0, 0);
    post[1]  = mkv(ri(5,12,15),        c_r(4'b0001),0, 0, 32'd0,        32'd0,        1, 4, 0, 0, 0, 0, 0);

    RST = 1'b1; INST = '0; inst_valid = 0; dmem_ack = 0; dmem_rdata = '0;
    {regDst, regWrite, ALUSrc, ALUcontrol, memWrite, memRead, memtoReg} = '0;
    repeat (3) @(negedge CLK);
    chk("rst_ready",  -1, 32'(inst_ready), 32'd1);
    chk("rst_req",    -1, 32'(dmem_req),   32'd0);
    chk("rst_we",     -1, 32'(dmem_we),    32'd0);
    chk("rst_regW",   -1, regW,            32'd0);
    chk("rst_addr",   -1, addr,            32'd0);
    chk("rst_zero",   -1, 32'(is_Zero),    32'd0);
    chk("rst_done",   -1, 32'(done),       32'd0);
    chk("rst_err",    -1, 32'(err),        32'd0);
    RST = 1'b0;

    for (int i = 0; i < 22; i++) run(i, vecs[i]);

    // Reset while a load is waiting for its ack.
    INST = ii(0,5,16'h0040);
    {regDst, regWrite, ALUSrc, ALUcontrol, memWrite, memRead, memtoReg} = C_LW;
    inst_valid = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge CLK);
      inst_valid = 1'b0;
    end
    chk("mid_req_high", 100, 32'(dmem_req), 32'd1);
    RST = 1'b1;
    @(negedge CLK);
    chk("mid_rst_req",   100, 32'(dmem_req),   32'd0);
    chk("mid_rst_ready", 100, 32'(inst_ready), 32'd1);
    chk("mid_rst_done",  100, 32'({done, err}), 32'd0);
    chk("mid_rst_regW",  100, regW,            32'd0);
    chk("mid_rst_addr",  100, addr,            32'd0);
    $display("mid-MEM reset: req=%0b ready=%0b regW=%h", dmem_req, inst_ready, regW);
    RST = 1'b0;
    for (int i = 0; i < 2; i++) run(200 + i, post[i]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
